alu_ex_mem_stage: RTL and testbench
===================================

Name: alu_ex_mem_stage

Overview:
Pipeline register that sits directly downstream of the 32-bit Alu and consumes its result, compare and overflow outputs. It buffers one execute-stage result per cycle behind a valid/ready handshake, with a 2-entry skid buffer, and drives the memory/writeback stage. It also resolves branches from the Alu compare flag and raises a precise arithmetic-overflow exception for signed ADD/SUB.

Parameters:
DATA_W, 32, width of Alu operands/result, PC and branch target
REG_W, 5, destination register index width

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  upstream Alu slot holds a valid instruction
in_ready  output  1  stage can accept this cycle
alu_out  input  DATA_W  Alu result
alu_cmp  input  1  Alu compare flag
alu_ov  input  1  Alu overflow flag
alu_op  input  3  Alu opcode (000 AND, 001 OR, 010 ADD, 100 NOR, 101 XOR, 110 SUB)
alu_uns  input  1  1 = unsigned operation
in_rd  input  REG_W  destination register
in_reg_write  input  1  instruction writes rd
in_is_branch  input  1  instruction is a conditional branch
in_target  input  DATA_W  branch target
in_pc  input  DATA_W  instruction PC
flush  input  1  squash all buffered entries
out_valid  output  1  head entry valid
out_ready  input  1  downstream accepts head
out_result  output  DATA_W  head result
out_rd  output  REG_W  head destination
out_reg_write  output  1  head write enable (already squashed on trap)
branch_taken  output  1  one-cycle pulse, registered
branch_target  output  DATA_W  valid while branch_taken=1
exc_valid  output  1  level, high in TRAP state
exc_epc  output  DATA_W  PC of the trapping instruction
exc_ack  input  1  exception handler acknowledge

Behaviour:
- Reset (rst_n=0, asynchronous): both entries invalid, state=RUN, in_ready=1 after reset release. All other outputs are 0: out_valid, out_result, out_rd, out_reg_write, branch_taken, branch_target, exc_valid, exc_epc.
- Buffer: 2 entries, head and skid. Accept occurs when in_valid & in_ready. Pop occurs when out_valid & out_ready.
- in_ready is registered: it is 1 iff the skid entry is empty and state=RUN. An accept with the head occupied and not popping fills the skid entry, and in_ready drops the next cycle.
- Latency: an accepted entry appears at out_* the next cycle if the head is free or popping. Simultaneous accept and pop with the skid empty keeps occupancy at 1.
- On pop with the skid full, skid moves to head in the same edge.
- Trap condition: alu_ov & ~alu_uns & (alu_op==010 | alu_op==110). Overflow with uns=1, or on any other opcode, is ignored.
- On accepting a trapping instruction:
  - The entry is still enqueued, with reg_write forced to 0.
  - exc_epc <= in_pc.
  - state -> TRAP; exc_valid=1 from the next cycle.
  - in_ready=0 while in TRAP.
  - Already-buffered entries continue to drain.
- TRAP -> RUN on exc_ack=1. exc_valid clears the next cycle; exc_epc holds its value. exc_ack in RUN is ignored.
- Branch: accepting an entry with in_is_branch & alu_cmp gives branch_taken=1 for exactly one cycle the next cycle, with branch_target <= in_target. Branch entries enqueue with reg_write forced 0. A not-taken branch produces no pulse. A trapping instruction never asserts branch_taken.
- flush=1 (synchronous, highest priority over accept/pop):
  - Both entries are invalidated; any same-cycle accept is discarded.
  - state -> RUN, exc_valid -> 0, branch_taken -> 0.
  - exc_epc and out_result hold their values.
- Result width: out_result is alu_out passed through unchanged, DATA_W bits. No sign handling.
- Holding: while out_valid=1 & out_ready=0, all out_* remain stable.

Test Plan:
- Reset mid-stream: fill both entries, then pulse rst_n=0 asynchronously between edges -> out_valid, in_ready, exc_valid and branch_taken go 0 immediately; in_ready=1 at the first edge after release.
- Back-pressure: out_ready=0 and accept ADD results 2, 0, 1 -> first two held (out_result=2), in_ready=0 after the second, the third is not accepted until out_ready=1. Then results drain in order 2, 0, 1.
- Signed overflow: op=010, uns=0, alu_out=0x00000002, alu_ov=1, pc=0x100, rd=5, reg_write=1 -> entry out with out_reg_write=0, exc_valid=1, exc_epc=0x100, in_ready=0 until exc_ack. Same stimulus with uns=1 -> no exception, out_reg_write=1.
- Overflow on non-arith op: op=101 with alu_ov=1, uns=0 -> no exception.
- Branch: in_is_branch=1, alu_cmp=1, target=0x40 -> branch_taken high one cycle with branch_target=0x40. Same with alu_cmp=0 -> no pulse.
- Flush: two entries buffered, state TRAP, flush=1 together with in_valid=1 -> next cycle out_valid=0, exc_valid=0, in_ready=1, and the incoming instruction is dropped.

Source files
------------

// File: rtl/alu_ex_mem_stage.sv
// Execute-to-memory pipeline register behind the 32-bit Alu.
// Holds up to two results (head + skid) behind a valid/ready handshake,
// resolves taken branches into a one-cycle pulse and converts signed
// ADD/SUB overflow into a precise exception that stalls intake until acked.
module alu_ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_cmp,
  input  logic              alu_ov,
  input  logic [2:0]        alu_op,
  input  logic              alu_uns,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_reg_write,
  input  logic              in_is_branch,
  input  logic [DATA_W-1:0] in_target,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_reg_write,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target,
  output logic              exc_valid,
  output logic [DATA_W-1:0] exc_epc,
  input  logic              exc_ack
);

  typedef enum logic {ST_RUN, ST_TRAP} state_t;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;

  state_t              state_q, state_d;
  logic                rdy_q, rdy_d;
  logic                head_vld_q, head_vld_d;
  logic [DATA_W-1:0]   head_res_q, head_res_d;
  logic [REG_W-1:0]    head_rd_q, head_rd_d;
  logic                head_rw_q, head_rw_d;
  logic                skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0]   skid_res_q, skid_res_d;
  logic [REG_W-1:0]    skid_rd_q, skid_rd_d;
  logic                skid_rw_q, skid_rw_d;
  logic                bt_q, bt_d;
  logic [DATA_W-1:0]   btgt_q, btgt_d;
  logic [DATA_W-1:0]   epc_q, epc_d;

  logic accept;
  logic pop;
  logic trap_hit;
  logic in_rw;

  // Handshake decode and next-state for buffer, trap FSM and branch pulse.
  always_comb begin
    accept   = in_valid & rdy_q;
    pop      = head_vld_q & out_ready;
    // Only signed add/subtract can trap; unsigned wrap and logic-op flags are benign.
    trap_hit = alu_ov & ~alu_uns & ((alu_op == OP_ADD) | (alu_op == OP_SUB));
    // Trapping and branch instructions never commit a register write.
    in_rw    = in_reg_write & ~trap_hit & ~in_is_branch;

    state_d    = state_q;
    head_vld_d = head_vld_q;
    head_res_d = head_res_q;
    head_rd_d  = head_rd_q;
    head_rw_d  = head_rw_q;
    skid_vld_d = skid_vld_q;
    skid_res_d = skid_res_q;
    skid_rd_d  = skid_rd_q;
    skid_rw_d  = skid_rw_q;
    bt_d       = 1'b0;
    btgt_d     = btgt_q;
    epc_d      = epc_q;

    if (flush) begin
      // Squash everything, including this cycle's accept; payloads are left as-is.
      head_vld_d = 1'b0;
      skid_vld_d = 1'b0;
      state_d    = ST_RUN;
    end else begin
      if (pop) begin
        if (skid_vld_q) begin
          // in_ready was low (skid full), so no accept can coincide here.
          head_vld_d = 1'b1;
          head_res_d = skid_res_q;
          head_rd_d  = skid_rd_q;
          head_rw_d  = skid_rw_q;
          skid_vld_d = 1'b0;
        end else if (accept) begin
          head_vld_d = 1'b1;
          head_res_d = alu_out;
          head_rd_d  = in_rd;
          head_rw_d  = in_rw;
        end else begin
          head_vld_d = 1'b0;
        end
      end else if (accept) begin
        if (head_vld_q) begin
          skid_vld_d = 1'b1;
          skid_res_d = alu_out;
          skid_rd_d  = in_rd;
          skid_rw_d  = in_rw;
        end else begin
          head_vld_d = 1'b1;
          head_res_d = alu_out;
          head_rd_d  = in_rd;
          head_rw_d  = in_rw;
        end
      end

      if (accept && trap_hit) begin
        state_d = ST_TRAP;
        epc_d   = in_pc;
      end else if (state_q == ST_TRAP && exc_ack) begin
        state_d = ST_RUN;
      end

      if (accept && in_is_branch && alu_cmp && !trap_hit) begin
        bt_d   = 1'b1;
        btgt_d = in_target;
      end
    end

    // Registered ready: open only with a free skid slot and no pending trap.
    rdy_d = ~skid_vld_d & (state_d == ST_RUN);
  end

  // State and payload registers; everything clears on asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      rdy_q      <= 1'b0;
      head_vld_q <= 1'b0;
      head_res_q <= '0;
      head_rd_q  <= '0;
      head_rw_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      skid_res_q <= '0;
      skid_rd_q  <= '0;
      skid_rw_q  <= 1'b0;
      bt_q       <= 1'b0;
      btgt_q     <= '0;
      epc_q      <= '0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= rdy_d;
      head_vld_q <= head_vld_d;
      head_res_q <= head_res_d;
      head_rd_q  <= head_rd_d;
      head_rw_q  <= head_rw_d;
      skid_vld_q <= skid_vld_d;
      skid_res_q <= skid_res_d;
      skid_rd_q  <= skid_rd_d;
      skid_rw_q  <= skid_rw_d;
      bt_q       <= bt_d;
      btgt_q     <= btgt_d;
      epc_q      <= epc_d;
    end
  end

  assign in_ready      = rdy_q;
  assign out_valid     = head_vld_q;
  assign out_result    = head_res_q;
  assign out_rd        = head_rd_q;
  assign out_reg_write = head_rw_q;
  assign branch_taken  = bt_q;
  assign branch_target = btgt_q;
  assign exc_valid     = (state_q == ST_TRAP);
  assign exc_epc       = epc_q;

endmodule

// File: tb/tb_alu_ex_mem_stage.sv
// Bench for alu_ex_mem_stage: directed vector table, hand-written
// multi-cycle sequences and random traffic against a queue-based model.
module tb_alu_ex_mem_stage;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_out;
  logic              alu_cmp;
  logic              alu_ov;
  logic [2:0]        alu_op;
  logic              alu_uns;
  logic [REG_W-1:0]  in_rd;
  logic              in_reg_write;
  logic              in_is_branch;
  logic [DATA_W-1:0] in_target;
  logic [DATA_W-1:0] in_pc;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [REG_W-1:0]  out_rd;
  logic              out_reg_write;
  logic              branch_taken;
  logic [DATA_W-1:0] branch_target;
  logic              exc_valid;
  logic [DATA_W-1:0] exc_epc;
  logic              exc_ack;

  always #5 clk = ~clk;

  alu_ex_mem_stage #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .alu_cmp(alu_cmp), .alu_ov(alu_ov), .alu_op(alu_op),
    .alu_uns(alu_uns), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .in_is_branch(in_is_branch), .in_target(in_target), .in_pc(in_pc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_reg_write(out_reg_write),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .exc_valid(exc_valid), .exc_epc(exc_epc), .exc_ack(exc_ack)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: an ordered queue of at most two pending results.
  typedef struct {
    logic [DATA_W-1:0] res;
    logic [REG_W-1:0]  rd;
    logic              rw;
  } ent_t;

  ent_t              mq[$];
  bit                m_trap;
  bit                m_bt;
  bit                m_fresh;
  logic [DATA_W-1:0] m_epc;
  logic [DATA_W-1:0] m_tgt;

  typedef struct {
    logic [2:0]        op;
    logic              uns;
    logic              ov;
    logic              cmp;
    logic              br;
    logic              rw;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] tgt;
    logic [DATA_W-1:0] pc;
    logic [REG_W-1:0]  rd;
    logic              e_rw;
    logic              e_exc;
    logic              e_bt;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic bit m_ready();
    return !m_fresh && (mq.size() < 2) && !m_trap;
  endfunction

  function automatic bit traps(input logic ov, input logic uns, input logic [2:0] op);
    return ov && !uns && (op == 3'd2 || op == 3'd6);
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit   acc;
    bit   pop;
    bit   tc;
    ent_t e;
    acc = in_valid && m_ready();
    pop = (mq.size() > 0) && out_ready;
    tc  = traps(alu_ov, alu_uns, alu_op);
    m_fresh = 1'b0;
    if (flush) begin
      mq.delete();
      m_trap = 1'b0;
      m_bt   = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) begin
        e.res = alu_out;
        e.rd  = in_rd;
        e.rw  = in_reg_write && !tc && !in_is_branch;
        mq.push_back(e);
      end
      if (acc && tc) begin
        m_trap = 1'b1;
        m_epc  = in_pc;
      end else if (m_trap && exc_ack) begin
        m_trap = 1'b0;
      end
      m_bt = acc && in_is_branch && alu_cmp && !tc;
      if (m_bt) m_tgt = in_target;
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_trap  = 1'b0;
    m_bt    = 1'b0;
    m_fresh = 1'b1;
    m_epc   = '0;
    m_tgt   = '0;
  endtask

  task automatic check_all();
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(m_ready()));
    chk("exc_valid", 32'(exc_valid), 32'(m_trap));
    chk("branch_taken", 32'(branch_taken), 32'(m_bt));
    if (mq.size() > 0) begin
      chk("out_result", out_result, mq[0].res);
      chk("out_rd", 32'(out_rd), 32'(mq[0].rd));
      chk("out_reg_write", 32'(out_reg_write), 32'(mq[0].rw));
    end
    if (m_trap) chk("exc_epc", exc_epc, m_epc);
    if (m_bt) chk("branch_target", branch_target, m_tgt);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    in_valid = 0; alu_out = '0; alu_cmp = 0; alu_ov = 0; alu_op = 3'd0;
    alu_uns = 0; in_rd = '0; in_reg_write = 0; in_is_branch = 0;
    in_target = '0; in_pc = '0; flush = 0; exc_ack = 0;
  endtask

  task automatic drive_add(input logic [DATA_W-1:0] res, input logic [REG_W-1:0] rd);
    idle();
    in_valid = 1; alu_op = 3'd2; alu_out = res; in_rd = rd; in_reg_write = 1;
    in_pc = 32'h200 + res;
  endtask

  initial begin
    logic [2:0] ops[6];
    ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};

    tbl[0] = '{3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h2,        32'h0,  32'h100, 5'd5, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h2,        32'h0,  32'h100, 5'd5, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{3'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80000001, 32'h0,  32'h104, 5'd7, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h12345678, 32'h0,  32'h108, 5'd9, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{3'd6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0,        32'h40, 32'h10c, 5'd1, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{3'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h5,        32'h44, 32'h110, 5'd2, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hdeadbeef, 32'h0,  32'h114, 5'd31, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h7,        32'h80, 32'h118, 5'd3, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hffff0000, 32'h0,  32'h11c, 5'd4, 1'b0, 1'b0, 1'b0};

    // Power-on reset.
    idle();
    out_ready = 1;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst out_result", out_result, 32'd0);
    chk("rst out_rd", 32'(out_rd), 32'd0);
    chk("rst out_reg_write", 32'(out_reg_write), 32'd0);
    chk("rst branch_taken", 32'(branch_taken), 32'd0);
    chk("rst branch_target", branch_target, 32'd0);
    chk("rst exc_valid", 32'(exc_valid), 32'd0);
    chk("rst exc_epc", exc_epc, 32'd0);
    #2 rst_n = 1;
    tick();
    chk("rst release in_ready", 32'(in_ready), 32'd1);

    // Back-pressure: results 2, 0, 1 with the consumer stalled.
    out_ready = 0;
    drive_add(32'd2, 5'd10);
    tick();
    chk("bp first out_result", out_result, 32'd2);
    drive_add(32'd0, 5'd11);
    tick();
    chk("bp held out_result", out_result, 32'd2);
    chk("bp full in_ready", 32'(in_ready), 32'd0);
    drive_add(32'd1, 5'd12);
    tick();
    chk("bp stalled out_result", out_result, 32'd2);
    chk("bp stalled out_rd", 32'(out_rd), 32'd10);
    out_ready = 1;
    tick();
    chk("bp drain second", out_result, 32'd0);
    tick();
    chk("bp drain third", out_result, 32'd1);
    idle();
    tick();
    chk("bp drained out_valid", 32'(out_valid), 32'd0);

    // Single-instruction vectors from an empty, running stage.
    for (int i = 0; i < 9; i++) begin
      idle();
      in_valid = 1; alu_op = tbl[i].op; alu_uns = tbl[i].uns; alu_ov = tbl[i].ov;
      alu_cmp = tbl[i].cmp; in_is_branch = tbl[i].br; in_reg_write = tbl[i].rw;
      alu_out = tbl[i].res; in_target = tbl[i].tgt; in_pc = tbl[i].pc; in_rd = tbl[i].rd;
      tick();
      chk($sformatf("vec%0d out_result", i), out_result, tbl[i].res);
      chk($sformatf("vec%0d out_reg_write", i), 32'(out_reg_write), 32'(tbl[i].e_rw));
      chk($sformatf("vec%0d exc_valid", i), 32'(exc_valid), 32'(tbl[i].e_exc));
      chk($sformatf("vec%0d branch_taken", i), 32'(branch_taken), 32'(tbl[i].e_bt));
      if (tbl[i].e_exc) begin
        chk($sformatf("vec%0d exc_epc", i), exc_epc, tbl[i].pc);
        chk($sformatf("vec%0d trap in_ready", i), 32'(in_ready), 32'd0);
      end
      if (tbl[i].e_bt) chk($sformatf("vec%0d branch_target", i), branch_target, tbl[i].tgt);
      idle();
      tick();
      chk($sformatf("vec%0d pulse end", i), 32'(branch_taken), 32'd0);
      chk($sformatf("vec%0d still trapped", i), 32'(exc_valid), 32'(tbl[i].e_exc));
      exc_ack = 1;
      tick();
      chk($sformatf("vec%0d ack exc_valid", i), 32'(exc_valid), 32'd0);
      chk($sformatf("vec%0d ack in_ready", i), 32'(in_ready), 32'd1);
      if (tbl[i].e_exc) chk($sformatf("vec%0d epc held", i), exc_epc, tbl[i].pc);
      idle();
    end

    // Flush with two entries buffered and a trap pending.
    out_ready = 0;
    drive_add(32'h55, 5'd6);
    tick();
    drive_add(32'h66, 5'd8);
    alu_ov = 1;
    tick();
    chk("fl trapped", 32'(exc_valid), 32'd1);
    chk("fl trap in_ready", 32'(in_ready), 32'd0);
    drive_add(32'h77, 5'd9);
    flush = 1;
    tick();
    chk("fl out_valid", 32'(out_valid), 32'd0);
    chk("fl exc_valid", 32'(exc_valid), 32'd0);
    chk("fl in_ready", 32'(in_ready), 32'd1);
    chk("fl result held", out_result, 32'h55);
    idle();
    out_ready = 1;
    tick();
    chk("fl dropped", 32'(out_valid), 32'd0);

    // Asynchronous reset in the middle of a full buffer.
    out_ready = 0;
    drive_add(32'h11, 5'd1);
    tick();
    drive_add(32'h22, 5'd2);
    in_is_branch = 1; alu_cmp = 1; in_target = 32'h300;
    tick();
    chk("mr branch pulse", 32'(branch_taken), 32'd1);
    idle();
    #2 rst_n = 0;
    #1;
    chk("mr out_valid", 32'(out_valid), 32'd0);
    chk("mr in_ready", 32'(in_ready), 32'd0);
    chk("mr exc_valid", 32'(exc_valid), 32'd0);
    chk("mr branch_taken", 32'(branch_taken), 32'd0);
    chk("mr out_result", out_result, 32'd0);
    #1 rst_n = 1;
    model_reset();
    out_ready = 1;
    tick();
    chk("mr release in_ready", 32'(in_ready), 32'd1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      in_valid     = ($urandom_range(0, 99) < 70);
      out_ready    = ($urandom_range(0, 99) < 60);
      flush        = ($urandom_range(0, 99) < 3);
      exc_ack      = ($urandom_range(0, 99) < 20);
      alu_ov       = ($urandom_range(0, 99) < 20);
      alu_uns      = 1'($urandom_range(0, 1));
      alu_cmp      = 1'($urandom_range(0, 1));
      in_is_branch = ($urandom_range(0, 99) < 25);
      in_reg_write = 1'($urandom_range(0, 1));
      alu_op       = ops[$urandom_range(0, 5)];
      alu_out      = $urandom;
      in_target    = $urandom;
      in_pc        = $urandom;
      in_rd        = 5'($urandom_range(0, 31));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
